// File: rtl/img_pkg.sv
// Shared definitions for the image read/write blocks of the Sobel pipeline:
// default frame geometry, the capture FSM state type and the buffer address
// width helper.
package img_pkg;

  localparam int IMG_W_DEF = 256;
  localparam int IMG_H_DEF = 256;
  localparam int DW_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LINE_WAIT = 2'd1,
    LINE      = 2'd2,
    DONE      = 2'd3
  } img_state_e;

  // Bits needed to address a w*h frame buffer (never less than one).
  function automatic int img_addr_width(input int w, input int h);
    return (w * h > 1) ? $clog2(w * h) : 1;
  endfunction

endpackage

// File: rtl/img_write_frame_ram.sv
// Simple dual-port frame buffer: one write port and one registered read port.
// The array itself is never reset; only the read register is.
// A same-cycle read and write of one address returns the old contents.
module frame_ram #(
  parameter int DEPTH = 16,
  parameter int DW    = 8,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // Store one pixel per enabled cycle.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read; sees the array before this edge's write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/img_write.sv
// img_write: frame-capture sink at the end of the Sobel pipeline.
// Tracks row/column from vsync/hsync, writes each valid pixel into the frame
// buffer through an incrementing pointer and raises frame_done when the last
// pixel of the frame is stored. Protocol errors (short line, early vsync)
// produce a one-cycle err pulse.
// Build option: define IMG_WRITE_BORDER_EN to store the outer ring of the
// image (first/last row, first/last column) as zero.
module img_write
  import img_pkg::*;
#(
  parameter  int IMG_W = IMG_W_DEF,
  parameter  int IMG_H = IMG_H_DEF,
  parameter  int DW    = DW_DEF,
  localparam int AW    = img_addr_width(IMG_W, IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  input  logic          vsync,
  input  logic          hsync,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          frame_done,
  output logic          busy,
  output logic          err
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  img_state_e    state, state_nxt;
  logic [RW-1:0] row, row_nxt;
  logic [CW-1:0] col, col_nxt;
  logic [AW-1:0] ptr, ptr_nxt;
  logic [AW-1:0] base, base_nxt;
  logic          err_nxt;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          last_row, last_col;
  logic [AW-1:0] next_base;

  assign last_row  = (row == RW'(IMG_H - 1));
  assign last_col  = (col == CW'(IMG_W - 1));
  assign next_base = base + AW'(IMG_W);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Position counters, write pointer, line base and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row  <= '0;
      col  <= '0;
      ptr  <= '0;
      base <= '0;
      err  <= 1'b0;
    end else begin
      row  <= row_nxt;
      col  <= col_nxt;
      ptr  <= ptr_nxt;
      base <= base_nxt;
      err  <= err_nxt;
    end
  end

  // Next-state and counter logic; vsync beats hsync, hsync beats the pixel.
  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    col_nxt   = col;
    ptr_nxt   = ptr;
    base_nxt  = base;
    err_nxt   = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = ptr;
    unique case (state)
      IDLE, DONE: begin
        if (vsync) begin
          state_nxt = LINE_WAIT;
          row_nxt   = '0;
          col_nxt   = '0;
          ptr_nxt   = '0;
          base_nxt  = '0;
        end
      end
      LINE_WAIT: begin
        if (vsync) begin
          err_nxt   = 1'b1;
          row_nxt   = '0;
          col_nxt   = '0;
          ptr_nxt   = '0;
          base_nxt  = '0;
        end else if (hsync) begin
          state_nxt = LINE;
          col_nxt   = '0;
          ptr_nxt   = base;
          if (in_valid) begin
            wr_en   = 1'b1;
            wr_addr = base;
            col_nxt = CW'(1);
            ptr_nxt = base + AW'(1);
          end
        end
      end
      LINE: begin
        if (vsync) begin
          err_nxt   = 1'b1;
          state_nxt = LINE_WAIT;
          row_nxt   = '0;
          col_nxt   = '0;
          ptr_nxt   = '0;
          base_nxt  = '0;
        end else if (hsync) begin
          err_nxt = (col < CW'(IMG_W - 1));
          col_nxt = '0;
          if (last_row) begin
            state_nxt = DONE;
            row_nxt   = '0;
            ptr_nxt   = '0;
            base_nxt  = '0;
          end else begin
            row_nxt  = row + RW'(1);
            base_nxt = next_base;
            ptr_nxt  = next_base;
            if (in_valid) begin
              wr_en   = 1'b1;
              wr_addr = next_base;
              col_nxt = CW'(1);
              ptr_nxt = next_base + AW'(1);
            end
          end
        end else if (in_valid) begin
          wr_en = 1'b1;
          if (last_col) begin
            col_nxt = '0;
            if (last_row) begin
              state_nxt = DONE;
              row_nxt   = '0;
              ptr_nxt   = '0;
              base_nxt  = '0;
            end else begin
              state_nxt = LINE_WAIT;
              row_nxt   = row + RW'(1);
              base_nxt  = next_base;
              ptr_nxt   = next_base;
            end
          end else begin
            col_nxt = col + CW'(1);
            ptr_nxt = ptr + AW'(1);
          end
        end
      end
    endcase
  end

`ifdef IMG_WRITE_BORDER_EN
  logic [RW-1:0] wr_row;
  logic [CW-1:0] wr_col;

  // Position of the pixel being written, used to blank the image border.
  always_comb begin
    wr_row  = (state == LINE && hsync) ? row + RW'(1) : row;
    wr_col  = hsync ? '0 : col;
    wr_data = in_data;
    if (wr_row == '0 || wr_row == RW'(IMG_H - 1) ||
        wr_col == '0 || wr_col == CW'(IMG_W - 1))
      wr_data = '0;
  end
`else
  // Pixels are stored exactly as received.
  always_comb wr_data = in_data;
`endif

  // Status outputs follow the state directly.
  always_comb begin
    busy       = (state == LINE_WAIT) || (state == LINE);
    frame_done = (state == DONE);
  end

  frame_ram #(
    .DEPTH (IMG_W * IMG_H),
    .DW    (DW),
    .AW    (AW)
  ) u_frame_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: doc/img_write.md
# img_write

Frame-capture sink at the output end of the Sobel pipeline: consumes the processed pixel stream (`out_data` of the masking stage plus line/frame syncs), counts column/row position, and writes each pixel into an internal frame buffer. Once a full frame is stored it raises `frame_done`, and a synchronous read port lets the bench or a downstream dumper fetch the result image. It is the writer counterpart of `img_read`.

## Interface
Parameters:
- `IMG_W`, 256: pixels per line (≥4).
- `IMG_H`, 256: lines per frame (≥3).
- `DW`, 8: pixel width.
- `AW`, $clog2(IMG_W*IMG_H): buffer address width (derived, not overridden).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_data` in DW: processed pixel.
- `in_valid` in 1: `in_data` qualifier.
- `vsync` in 1: one-cycle start-of-frame pulse, precedes the first `hsync`.
- `hsync` in 1: one-cycle start-of-line pulse, precedes that line's pixels.
- `rd_addr` in AW: read address, row*IMG_W+col.
- `rd_data` out DW: buffer data, 1-cycle latency.
- `frame_done` out 1: level; full frame stored.
- `busy` out 1: frame capture in progress.
- `err` out 1: one-cycle pulse on protocol error.

## Operation
- FSM states IDLE, LINE_WAIT, LINE, DONE.
  - IDLE: ignore everything except `vsync`. On `vsync`: row=0, col=0, `busy`=1, go to LINE_WAIT.
  - LINE_WAIT: `in_valid` pixels are dropped. On `hsync`: col=0, go to LINE.
  - LINE: each `in_valid` cycle writes `in_data` at row*IMG_W+col and increments col. On the write with col=IMG_W-1: if row=IMG_H-1, go to DONE; else row+1, go to LINE_WAIT.
  - DONE: `frame_done`=1, `busy`=0. On `vsync`: clear `frame_done` and start a new frame as in IDLE.
- Short line: `hsync` in LINE with col<IMG_W-1 pulses `err`. Remaining pixels of that row keep their old contents. Then row+1 and col=0, staying in LINE. If row was IMG_H-1, go to DONE instead.
- Early frame: `vsync` in LINE_WAIT or LINE pulses `err`, then restarts at row=0, col=0, LINE_WAIT.
- `hsync` and `in_valid` in the same cycle: `hsync` is processed first, and the pixel is written as col 0.
- `vsync` and `hsync` in the same cycle: `vsync` wins and `hsync` is ignored.
- Address is formed by an incrementing pointer, not a multiplier. It wraps only via the FSM; it never exceeds IMG_W*IMG_H-1.
- Reads are allowed in any state. A read and a write to the same address in the same cycle return the old data.
- Reset values: state IDLE, row/col 0, `frame_done` 0, `busy` 0, `err` 0, `rd_data` 0. Buffer contents are not reset.
- Reset asserted mid-frame aborts capture immediately. Already-written pixels remain in the buffer.

## Timing
- Write latency: a pixel accepted at edge N is readable by a `rd_addr` presented in cycle N+1, with data at edge N+2.
- `frame_done` rises on the edge that writes the last pixel of the frame.
- `err` is high for exactly one cycle, the cycle after the offending sync edge.
- No backpressure: the block accepts one pixel per cycle indefinitely.

## Configuration
- `IMG_WRITE_BORDER_EN` defined: pixels at row 0, row IMG_H-1, col 0 or col IMG_W-1 are written as 0 regardless of `in_data`. This masks the invalid Sobel edge outputs.
- Undefined: every pixel is stored as received.
- Counting, timing and `frame_done` are identical in both builds.

## Structure
- Shared package `img_pkg`: `IMG_W`/`IMG_H`/`DW` defaults, the FSM state enum, and the address-width function. `img_read` uses the same package.
- One sub-module, `frame_ram`: simple dual-port, one write port and one registered read port, depth IMG_W*IMG_H, no reset on the array.

## Test plan
All scenarios use IMG_W=4, IMG_H=3.
- Nominal frame: `vsync`, then 3× (`hsync` + pixels 1..4 with row offset 0x10 per row). Required: `frame_done` on the 12th write; `rd_addr`=5 gives 0x12; `rd_addr`=11 gives 0x24 (0 with `IMG_WRITE_BORDER_EN`, and `rd_addr`=5 still 0x12).
- Idle gaps: `in_valid` deasserted randomly within lines, plus 5 stray pixels before the first `hsync`. Required: the same buffer image as the nominal frame; the stray pixels are not stored.
- Short line: row 1 carries only 2 pixels before the next `hsync`. Required: `err` pulses once; addr 6..7 keep their prior values; row 2 is stored at addr 8..11; `frame_done` is set.
- Early `vsync` after 6 pixels. Required: `err` pulses once, `busy` stays 1, and the following full frame is stored correctly with `frame_done` set.
- Reset mid-frame after 7 pixels. Required: all outputs return to reset values at once; pixels without a preceding `vsync` are ignored; a new `vsync` frame completes normally.
- Read/write collision: read addr 3 in the same cycle as its write of 0xAA over old 0x55. Required: 0x55 returned, then 0xAA on the next read.
